// File: rtl/scrf_loader.sv
// scrf_loader: runtime-programmable system config register file.
// Host words are collected into shadow registers over a valid/ready port.
// The last word of a load commits every shadow register to the active
// outputs in one edge, unless downstream holds the commit off.
module scrf_loader #(
    parameter int NUM_IPORT = 12,
    parameter int NUM_OPORT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [5:0]              cfg_addr,
    input  logic [31:0]             cfg_data,
    input  logic                    cfg_last,
    input  logic                    cfg_hold,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic                    config_valid,
    output logic [22:0]             dfsm_config,
    output logic [19:0]             ssp_config,
    output logic [37:0]             quabuf_config,
    output logic [25:0]             singbuf_config,
    output logic [9:0]              mode_flags,
    output logic [56*NUM_IPORT-1:0] iport_configbits,
    output logic [56*NUM_OPORT-1:0] oport_configbits
);

    localparam int IPORT_BASE = 6;
    localparam int OPORT_BASE = IPORT_BASE + 2 * NUM_IPORT;
    localparam int NUM_WORDS  = OPORT_BASE + 2 * NUM_OPORT;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic                    accept;
    logic                    addrBad;
    logic                    commitNow;

    logic [22:0]             dfsmShadow_q;
    logic [19:0]             sspShadow_q;
    logic [37:0]             quabufShadow_q;
    logic [25:0]             singbufShadow_q;
    logic [9:0]              modeShadow_q;
    logic [56*NUM_IPORT-1:0] iportShadow_q;
    logic [56*NUM_OPORT-1:0] oportShadow_q;

    logic [22:0]             dfsmActive_q;
    logic [19:0]             sspActive_q;
    logic [37:0]             quabufActive_q;
    logic [25:0]             singbufActive_q;
    logic [9:0]              modeActive_q;
    logic [56*NUM_IPORT-1:0] iportActive_q;
    logic [56*NUM_OPORT-1:0] oportActive_q;

    logic                    done_q;
    logic                    err_q;
    logic                    cfgValid_q;

    // Ready is purely a state decode so it never depends on cfg_valid.
    assign cfg_ready = (state_q != COMMIT);
    assign accept    = cfg_valid && cfg_ready;
    assign addrBad   = ({1'b0, cfg_addr} >= 7'(NUM_WORDS));
    assign commitNow = (state_q == COMMIT) && !cfg_hold;

    // Next-state logic: a last word always leads to COMMIT, hold parks us there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cfg_last ? COMMIT : LOAD;
                end
            end
            LOAD: begin
                if (accept && cfg_last) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (!cfg_hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the registered status flags (done, err, valid).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cfgValid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= commitNow;
            if (commitNow) begin
                cfgValid_q <= 1'b1;
            end
            if (accept) begin
                if (state_q == IDLE) begin
                    err_q <= addrBad;
                end else begin
                    err_q <= err_q | addrBad;
                end
            end
        end
    end

    // Shadow capture: each accepted in-range word updates only its own slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfsmShadow_q    <= '0;
            sspShadow_q     <= '0;
            quabufShadow_q  <= '0;
            singbufShadow_q <= '0;
            modeShadow_q    <= '0;
            iportShadow_q   <= '0;
            oportShadow_q   <= '0;
        end else if (accept) begin
            case (cfg_addr)
                6'd0: dfsmShadow_q          <= cfg_data[22:0];
                6'd1: sspShadow_q           <= cfg_data[19:0];
                6'd2: quabufShadow_q[31:0]  <= cfg_data;
                6'd3: quabufShadow_q[37:32] <= cfg_data[5:0];
                6'd4: singbufShadow_q       <= cfg_data[25:0];
                6'd5: modeShadow_q          <= cfg_data[9:0];
                default: begin
                    for (int n = 0; n < NUM_IPORT; n++) begin
                        if (cfg_addr == 6'(IPORT_BASE + 2 * n)) begin
                            iportShadow_q[56*n +: 32] <= cfg_data;
                        end
                        if (cfg_addr == 6'(IPORT_BASE + 2 * n + 1)) begin
                            iportShadow_q[56*n+32 +: 24] <= cfg_data[23:0];
                        end
                    end
                    for (int m = 0; m < NUM_OPORT; m++) begin
                        if (cfg_addr == 6'(OPORT_BASE + 2 * m)) begin
                            oportShadow_q[56*m +: 32] <= cfg_data;
                        end
                        if (cfg_addr == 6'(OPORT_BASE + 2 * m + 1)) begin
                            oportShadow_q[56*m+32 +: 24] <= cfg_data[23:0];
                        end
                    end
                end
            endcase
        end
    end

    // Atomic commit: every active field takes its shadow value on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfsmActive_q    <= '0;
            sspActive_q     <= '0;
            quabufActive_q  <= '0;
            singbufActive_q <= '0;
            modeActive_q    <= '0;
            iportActive_q   <= '0;
            oportActive_q   <= '0;
        end else if (commitNow) begin
            dfsmActive_q    <= dfsmShadow_q;
            sspActive_q     <= sspShadow_q;
            quabufActive_q  <= quabufShadow_q;
            singbufActive_q <= singbufShadow_q;
            modeActive_q    <= modeShadow_q;
            iportActive_q   <= iportShadow_q;
            oportActive_q   <= oportShadow_q;
        end
    end

    assign cfg_done         = done_q;
    assign cfg_err          = err_q;
    assign config_valid     = cfgValid_q;
    assign dfsm_config      = dfsmActive_q;
    assign ssp_config       = sspActive_q;
    assign quabuf_config    = quabufActive_q;
    assign singbuf_config   = singbufActive_q;
    assign mode_flags       = modeActive_q;
    assign iport_configbits = iportActive_q;
    assign oport_configbits = oportActive_q;

endmodule

// File: tb/tb_scrf_loader.sv
// tb_scrf_loader: directed self-checking bench for scrf_loader.
module tb_scrf_loader;

    localparam int W = 672;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [5:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic         cfg_last;
    logic         cfg_hold;
    logic         cfg_done;
    logic         cfg_err;
    logic         config_valid;
    logic [22:0]  dfsm_config;
    logic [19:0]  ssp_config;
    logic [37:0]  quabuf_config;
    logic [25:0]  singbuf_config;
    logic [9:0]   mode_flags;
    logic [671:0] iport_configbits;
    logic [111:0] oport_configbits;

    logic [22:0]  expDfsm;
    logic [19:0]  expSsp;
    logic [37:0]  expQuabuf;
    logic [25:0]  expSingbuf;
    logic [9:0]   expMode;
    logic [671:0] expIport;
    logic [111:0] expOport;
    logic         expErr;
    logic         expValid;

    int checkCount;
    int passCount;

    scrf_loader #(
        .NUM_IPORT(12),
        .NUM_OPORT(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .cfg_last         (cfg_last),
        .cfg_hold         (cfg_hold),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err),
        .config_valid     (config_valid),
        .dfsm_config      (dfsm_config),
        .ssp_config       (ssp_config),
        .quabuf_config    (quabuf_config),
        .singbuf_config   (singbuf_config),
        .mode_flags       (mode_flags),
        .iport_configbits (iport_configbits),
        .oport_configbits (oport_configbits)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".dfsm"},    W'(dfsm_config),      W'(expDfsm));
        checkOutput({tag, ".ssp"},     W'(ssp_config),       W'(expSsp));
        checkOutput({tag, ".quabuf"},  W'(quabuf_config),    W'(expQuabuf));
        checkOutput({tag, ".singbuf"}, W'(singbuf_config),   W'(expSingbuf));
        checkOutput({tag, ".mode"},    W'(mode_flags),       W'(expMode));
        checkOutput({tag, ".iport"},   W'(iport_configbits), W'(expIport));
        checkOutput({tag, ".oport"},   W'(oport_configbits), W'(expOport));
        checkOutput({tag, ".err"},     W'(cfg_err),          W'(expErr));
        checkOutput({tag, ".valid"},   W'(config_valid),     W'(expValid));
        checkOutput({tag, ".ready"},   W'(cfg_ready),        W'(1));
    endtask

    // Starts and ends on a falling edge; the word is accepted on the rising edge between.
    task automatic applyStimulus(input logic [5:0] a, input logic [31:0] d,
                                 input logic l, input int gap);
        int t;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        repeat (gap) @(negedge clk);
        t = 0;
        while (!cfg_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            checkOutput("readyTimeout", W'(cfg_ready), W'(1));
        end
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = l;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // Reference word for each address; upper unused bits deliberately set.
    function automatic logic [31:0] wordData(input int a);
        int n;
        if (a == 0)      return 32'hFF88_0063;
        else if (a == 1) return 32'hFFFA_BCDE;
        else if (a == 2) return 32'h2000_1008;
        else if (a == 3) return 32'hFFFF_FFF0;
        else if (a == 4) return 32'hFE34_5678;
        else if (a == 5) return 32'hFFFF_FEA5;
        else if (a < 30) begin
            n = (a - 6) / 2;
            if ((a % 2) == 0) return (n == 0) ? 32'h0000_0006 : 32'h1000_0000 + n;
            else              return (n == 0) ? 32'hFF00_0009 : 32'hFF00_A000 + n;
        end else begin
            n = (a - 30) / 2;
            if ((a % 2) == 0) return 32'hC0DE_0000 + n;
            else              return 32'hFFBE_EF00 + n;
        end
    endfunction

    task automatic clearExpected();
        expDfsm    = '0;
        expSsp     = '0;
        expQuabuf  = '0;
        expSingbuf = '0;
        expMode    = '0;
        expIport   = '0;
        expOport   = '0;
        expErr     = 1'b0;
        expValid   = 1'b0;
    endtask

    // Directed scenario sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_last   = 1'b0;
        cfg_hold   = 1'b0;
        clearExpected();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkAll("reset");
        checkOutput("reset.done", W'(cfg_done), W'(0));

        // Full 34-word load, last on word 33.
        for (int a = 0; a < 34; a++) begin
            applyStimulus(6'(a), wordData(a), (a == 33), 0);
        end
        checkOutput("full.preDone",  W'(cfg_done),    W'(0));
        checkOutput("full.preReady", W'(cfg_ready),   W'(0));
        checkOutput("full.preDfsm",  W'(dfsm_config), W'(0));
        @(negedge clk);
        expDfsm    = 23'd524387;
        expSsp     = 20'hABCDE;
        expQuabuf  = 38'd206695305224;
        expSingbuf = 26'h2345678;
        expMode    = 10'h2A5;
        for (int n = 0; n < 12; n++) begin
            expIport[56*n +: 32]    = (n == 0) ? 32'd6 : 32'h1000_0000 + n;
            expIport[56*n+32 +: 24] = (n == 0) ? 24'd9 : 24'(32'h0000_A000 + n);
        end
        for (int m = 0; m < 2; m++) begin
            expOport[56*m +: 32]    = 32'hC0DE_0000 + m;
            expOport[56*m+32 +: 24] = 24'(32'h00BE_EF00 + m);
        end
        expValid = 1'b1;
        expErr   = 1'b0;
        checkOutput("full.done", W'(cfg_done), W'(1));
        checkAll("full");
        @(negedge clk);
        checkOutput("full.doneDrop", W'(cfg_done), W'(0));

        // Partial load of ssp with the commit held for five cycles.
        cfg_hold = 1'b1;
        applyStimulus(6'd1, 32'd12, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold%0d.ready", i), W'(cfg_ready),  W'(0));
            checkOutput($sformatf("hold%0d.done", i),  W'(cfg_done),   W'(0));
            checkOutput($sformatf("hold%0d.ssp", i),   W'(ssp_config), W'(expSsp));
            @(negedge clk);
        end
        cfg_hold = 1'b0;
        @(negedge clk);
        expSsp = 20'd12;
        checkOutput("hold.done", W'(cfg_done), W'(1));
        checkAll("partial");

        // Out-of-range address mid-load.
        applyStimulus(6'd5, 32'h0000_0155, 1'b0, 0);
        applyStimulus(6'd40, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(6'd2, 32'h1122_3344, 1'b1, 0);
        @(negedge clk);
        expMode          = 10'h155;
        expQuabuf[31:0]  = 32'h1122_3344;
        expErr           = 1'b1;
        checkOutput("badMid.done", W'(cfg_done), W'(1));
        checkAll("badMid");

        // A clean load clears the error.
        applyStimulus(6'd5, 32'h0000_02A5, 1'b1, 0);
        @(negedge clk);
        expMode = 10'h2A5;
        expErr  = 1'b0;
        checkAll("goodAfterBad");

        // Bad address on the last word still commits the rest.
        applyStimulus(6'd4, 32'h0000_1234, 1'b0, 0);
        applyStimulus(6'd63, 32'hDEAD_BEEF, 1'b1, 0);
        @(negedge clk);
        expSingbuf = 26'h0001234;
        expErr     = 1'b1;
        checkOutput("badLast.done", W'(cfg_done), W'(1));
        checkAll("badLast");

        // Reset between word 10 and word 11.
        for (int a = 0; a <= 10; a++) begin
            applyStimulus(6'(a), 32'h5A5A_5A5A ^ 32'(a), 1'b0, 0);
        end
        rst = 1'b1;
        #1;
        clearExpected();
        checkAll("midReset");
        checkOutput("midReset.done", W'(cfg_done), W'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("postReset%0d.done", i), W'(cfg_done), W'(0));
        end

        // Gaps and duplicate writes; shadows start from zero after reset.
        applyStimulus(6'd0,  32'd111,        1'b0, int'($urandom_range(0, 3)));
        applyStimulus(6'd7,  32'hFF00_0005,  1'b0, int'($urandom_range(0, 3)));
        applyStimulus(6'd0,  32'd222,        1'b0, int'($urandom_range(0, 3)));
        applyStimulus(6'd7,  32'h0000_0006,  1'b0, int'($urandom_range(0, 3)));
        applyStimulus(6'd33, 32'hFFBE_EF77,  1'b1, int'($urandom_range(0, 3)));
        checkOutput("dup.preDone",  W'(cfg_done),  W'(0));
        checkOutput("dup.preReady", W'(cfg_ready), W'(0));
        @(negedge clk);
        expDfsm             = 23'd222;
        expIport[55:32]     = 24'h000006;
        expOport[88 +: 24]  = 24'hBEEF77;
        expValid            = 1'b1;
        checkOutput("dup.done", W'(cfg_done), W'(1));
        checkAll("dup");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
